traverse_dl_router: RTL and testbench
=====================================

// Module: traverse_dl_router
// PURPOSE
// - Upstream of traverse_usa: demultiplexes the hps_io ioctl download stream into ROM writes, game-variant byte and DIP banks.
// - Generates the core reset, held through any download plus a post-download settle period.
// - Checks ROM image length; exposes status for LED/OSD.
// PARAMETERS
// - ROM_SIZE     default 17'h1_C000  exact expected ROM image length in bytes (index 0)
// - HOLD_CYCLES  default 1024        core_reset extension after download end, clk_sys cycles
// - DIP1_DEF     default 8'hFF       dip_switch_1 value after reset
// - DIP2_DEF     default 8'hFF       dip_switch_2 value after reset
// PORTS
// - clk_sys         in   1   system clock (36 MHz)
// - reset           in   1   asynchronous, active-high reset
// - user_reset      in   1   OSD/button/RESET request, level
// - ioctl_download  in   1   download active
// - ioctl_wr        in   1   byte strobe, one clk_sys cycle
// - ioctl_addr      in   25  byte address within current index
// - ioctl_dout      in   8   byte data
// - ioctl_index     in   8   0=ROM, 1=variant byte, 254=DIP; others ignored
// - dn_addr         out  17  ROM write address to traverse_usa
// - dn_data         out  8   ROM write data
// - dn_wr           out  1   ROM write strobe, one cycle
// - mod_shotrider   out  1   variant byte == 1
// - dip_switch_1    out  8   DIP bank 1
// - dip_switch_2    out  8   DIP bank 2
// - core_reset      out  1   reset to traverse_usa
// - rom_size_err    out  1   sticky: last ROM download length != ROM_SIZE
// - dl_busy         out  1   state != IDLE
// BEHAVIOUR
// - Reset values: dn_addr 0, dn_data 0, dn_wr 0, mod_shotrider 0, dips DIPx_DEF, core_reset 1, rom_size_err 0, dl_busy 1 (state HOLD, hold counter loaded with HOLD_CYCLES).
// - FSM: IDLE, ROM, MOD, DIP, HOLD. All outputs registered.
// - IDLE -> ROM/MOD/DIP on cycle ioctl_download is sampled 1 with index 0/1/254; other index -> IGNORE handled as DIP-less pass: stays IDLE, writes dropped.
// - Index is latched at download start; index changes mid-download ignored.
// - ROM: ioctl_wr with ioctl_addr < ROM_SIZE -> next cycle dn_wr=1, dn_addr=ioctl_addr[16:0], dn_data=ioctl_dout (latency 1). addr >= ROM_SIZE -> no dn_wr, over-range flag set.
//   18-bit byte counter increments per ioctl_wr, saturates at 2^18-1. Cleared on ROM entry.
// - MOD: each ioctl_wr latches byte; last byte wins; mod_shotrider = (byte == 8'd1), updated next cycle.
// - DIP: ioctl_wr with ioctl_addr[24:3]==0 and addr[2:0]==0/1 writes dip_switch_1/2; other addresses dropped.
// - Download end (ioctl_download sampled 0 in ROM/MOD/DIP) -> HOLD, counter = HOLD_CYCLES.
//   On leaving ROM: rom_size_err <= (count != ROM_SIZE) | over-range; updated only by ROM downloads.
// - HOLD: decrement each cycle; at 0 -> IDLE. New ioctl_download in HOLD -> directly to ROM/MOD/DIP per index.
// - core_reset = 1 whenever state != IDLE or user_reset (user_reset combinationally ORed into register input, 1-cycle latency).
// - ioctl_wr on the same cycle ioctl_download rises is processed (state entry and first write coincide).
// - Async reset mid-download: FSM to HOLD, ROM write in flight dropped, dips to defaults.
// STRUCTURE
// - Shared package traverse_pkg: state enum dl_state_t, index constants IDX_ROM=0, IDX_MOD=1, IDX_DIP=254, ROM_SIZE default.
// - Single module; hold counter and byte counter inline. No sub-module.
// TESTING
// - Reset release -> core_reset 1 for HOLD_CYCLES+1 cycles, dips = DIPx_DEF, then dl_busy 0, core_reset 0.
// - Index 0, ROM_SIZE bytes at addr 0..ROM_SIZE-1 -> ROM_SIZE dn_wr pulses, each 1 cycle after ioctl_wr with matching addr/data; rom_size_err 0.
// - Index 0, ROM_SIZE-1 bytes then 2 bytes beyond ROM_SIZE -> rom_size_err 1 after end, no dn_wr for over-range addrs; a correct download clears it.
// - Index 1, bytes 00,01 -> mod_shotrider 1; then download byte 00 -> 0; core_reset held throughout plus HOLD_CYCLES.
// - Index 254, addr 0=8'h5A, addr 1=8'hA5, addr 8=8'h00 -> dip1 5A, dip2 A5, addr 8 ignored; index 3 download -> no outputs change.
// - user_reset pulse in IDLE -> core_reset 1 one cycle later; second download started during HOLD -> no IDLE visit, writes accepted.

Source files
------------

// File: rtl/traverse_pkg.sv
// Shared types and constants for the traverse download router: FSM states,
// ioctl index codes and the default ROM image length.
package traverse_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ROM  = 3'd1,
    ST_MOD  = 3'd2,
    ST_DIP  = 3'd3,
    ST_HOLD = 3'd4
  } dl_state_t;

  localparam logic [7:0]  IDX_ROM      = 8'd0;
  localparam logic [7:0]  IDX_MOD      = 8'd1;
  localparam logic [7:0]  IDX_DIP      = 8'd254;
  localparam logic [16:0] ROM_SIZE_DEF = 17'h1_C000;
  localparam int unsigned BYTE_CNT_W   = 18;

  // Unrecognised indices map to ST_IDLE, meaning "no download state to enter".
  function automatic dl_state_t index_to_state(input logic [7:0] idx);
    case (idx)
      IDX_ROM: return ST_ROM;
      IDX_MOD: return ST_MOD;
      IDX_DIP: return ST_DIP;
      default: return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/traverse_dl_router.sv
// Splits the hps_io ioctl download stream into ROM writes, the variant byte
// and DIP banks; owns the core reset and the ROM length check.
module traverse_dl_router
  import traverse_pkg::*;
#(
  parameter logic [16:0] ROM_SIZE    = ROM_SIZE_DEF,
  parameter int unsigned HOLD_CYCLES = 1024,
  parameter logic [7:0]  DIP1_DEF    = 8'hFF,
  parameter logic [7:0]  DIP2_DEF    = 8'hFF
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        user_reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic [7:0]  ioctl_index,
  output logic [16:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic        dn_wr,
  output logic        mod_shotrider,
  output logic [7:0]  dip_switch_1,
  output logic [7:0]  dip_switch_2,
  output logic        core_reset,
  output logic        rom_size_err,
  output logic        dl_busy
);

  localparam int unsigned HOLD_W = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0]     HOLD_LOAD = HOLD_W'(HOLD_CYCLES);
  localparam logic [BYTE_CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [BYTE_CNT_W-1:0] ROM_LEN   = BYTE_CNT_W'(ROM_SIZE);
  localparam logic [24:0]           ROM_LIMIT = 25'(ROM_SIZE);

  dl_state_t             state_q, state_d;
  dl_state_t             req_state, work_state;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic [BYTE_CNT_W-1:0] cnt_q, cnt_d, cnt_base;
  logic                  over_q, over_d, over_base;
  logic                  rom_entry;
  logic                  err_q, err_d;
  logic [16:0]           dn_addr_q, dn_addr_d;
  logic [7:0]            dn_data_q, dn_data_d;
  logic                  dn_wr_q, dn_wr_d;
  logic                  mod_q, mod_d;
  logic [7:0]            dip1_q, dip1_d;
  logic [7:0]            dip2_q, dip2_d;
  logic                  core_reset_q, core_reset_d;
  logic                  busy_q, busy_d;

  // Next state, plus work_state: the mode that owns this cycle's ioctl_wr.
  // Entering a download and handling its first byte happen in the same cycle.
  always_comb begin
    req_state  = index_to_state(ioctl_index);
    work_state = ST_IDLE;
    state_d    = state_q;
    hold_d     = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (ioctl_download) begin
          state_d    = req_state;
          work_state = req_state;
        end
      end
      ST_HOLD: begin
        if (ioctl_download && (req_state != ST_IDLE)) begin
          state_d    = req_state;
          work_state = req_state;
        end else if (hold_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      default: begin
        if (ioctl_download) begin
          work_state = state_q;
        end else begin
          state_d = ST_HOLD;
          hold_d  = HOLD_LOAD;
        end
      end
    endcase
  end

  always_comb begin
    rom_entry = (state_q != ST_ROM) && (work_state == ST_ROM);
    cnt_base  = rom_entry ? '0 : cnt_q;
    over_base = rom_entry ? 1'b0 : over_q;
    cnt_d     = cnt_base;
    over_d    = over_base;
    dn_wr_d   = 1'b0;
    dn_addr_d = dn_addr_q;
    dn_data_d = dn_data_q;
    mod_d     = mod_q;
    dip1_d    = dip1_q;
    dip2_d    = dip2_q;
    err_d     = err_q;
    if (ioctl_wr) begin
      case (work_state)
        ST_ROM: begin
          if (cnt_base != CNT_MAX) cnt_d = cnt_base + BYTE_CNT_W'(1);
          if (ioctl_addr < ROM_LIMIT) begin
            dn_wr_d   = 1'b1;
            dn_addr_d = ioctl_addr[16:0];
            dn_data_d = ioctl_dout;
          end else begin
            over_d = 1'b1;
          end
        end
        ST_MOD: mod_d = (ioctl_dout == 8'd1);
        ST_DIP: begin
          if (ioctl_addr[24:3] == '0) begin
            if (ioctl_addr[2:0] == 3'd0)      dip1_d = ioctl_dout;
            else if (ioctl_addr[2:0] == 3'd1) dip2_d = ioctl_dout;
          end
        end
        default: ;
      endcase
    end
    // Leaving ROM only happens on a cycle with no accepted write, so cnt_q is final.
    if ((state_q == ST_ROM) && (state_d != ST_ROM)) begin
      err_d = (cnt_q != ROM_LEN) | over_q;
    end
    busy_d       = (state_d != ST_IDLE);
    core_reset_d = busy_d | user_reset;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q      <= ST_HOLD;
      hold_q       <= HOLD_LOAD;
      cnt_q        <= '0;
      over_q       <= 1'b0;
      err_q        <= 1'b0;
      dn_addr_q    <= '0;
      dn_data_q    <= '0;
      dn_wr_q      <= 1'b0;
      mod_q        <= 1'b0;
      dip1_q       <= DIP1_DEF;
      dip2_q       <= DIP2_DEF;
      core_reset_q <= 1'b1;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      cnt_q        <= cnt_d;
      over_q       <= over_d;
      err_q        <= err_d;
      dn_addr_q    <= dn_addr_d;
      dn_data_q    <= dn_data_d;
      dn_wr_q      <= dn_wr_d;
      mod_q        <= mod_d;
      dip1_q       <= dip1_d;
      dip2_q       <= dip2_d;
      core_reset_q <= core_reset_d;
      busy_q       <= busy_d;
    end
  end

  assign dn_addr       = dn_addr_q;
  assign dn_data       = dn_data_q;
  assign dn_wr         = dn_wr_q;
  assign mod_shotrider = mod_q;
  assign dip_switch_1  = dip1_q;
  assign dip_switch_2  = dip2_q;
  assign core_reset    = core_reset_q;
  assign rom_size_err  = err_q;
  assign dl_busy       = busy_q;

endmodule

// File: tb/tb_traverse_dl_router.sv
// Self-checking bench for traverse_dl_router: reset/hold timing, a hand-checked
// vector table, directed corner sequences and randomized downloads vs a model.
module tb_traverse_dl_router;

  localparam logic [16:0] RS = 17'd40;
  localparam int unsigned HC = 12;
  localparam logic [7:0]  D1 = 8'hC3;
  localparam logic [7:0]  D2 = 8'h3C;

  logic        clk = 1'b0;
  logic        reset, user_reset, ioctl_download, ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout, ioctl_index;
  logic [16:0] dn_addr;
  logic [7:0]  dn_data, dip_switch_1, dip_switch_2;
  logic        dn_wr, mod_shotrider, core_reset, rom_size_err, dl_busy;

  traverse_dl_router #(
    .ROM_SIZE(RS), .HOLD_CYCLES(HC), .DIP1_DEF(D1), .DIP2_DEF(D2)
  ) dut (
    .clk_sys(clk), .reset(reset), .user_reset(user_reset),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index),
    .dn_addr(dn_addr), .dn_data(dn_data), .dn_wr(dn_wr),
    .mod_shotrider(mod_shotrider), .dip_switch_1(dip_switch_1),
    .dip_switch_2(dip_switch_2), .core_reset(core_reset),
    .rom_size_err(rom_size_err), .dl_busy(dl_busy)
  );

  always #5 clk = ~clk;

  int unsigned n_pass = 0, n_total = 0, pulses = 0;

  // Reference model: transaction-level view of what the outputs should be.
  logic [7:0] m_dip1, m_dip2;
  logic       m_mod, m_err, m_over, m_active, in_hold;
  int         m_idx, m_cnt;

  typedef struct {
    bit          start;
    logic [7:0]  idx;
    logic [24:0] addr;
    logic [7:0]  data;
    bit          exp_wr;
    bit          exp_mod;
    logic [7:0]  exp_d1;
    logic [7:0]  exp_d2;
    bit          exp_busy;
  } rec_t;
  rec_t tbl[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_real(input int idx);
    return (idx == 0) || (idx == 1) || (idx == 254);
  endfunction

  // One cycle with an optional byte strobe, then compare against the model.
  task automatic drive_byte(input bit wr, input int addr, input logic [7:0] data);
    bit exp_wr = 0;
    if (wr && m_active) begin
      if (m_idx == 0) begin
        m_cnt++;
        if (addr < int'(RS)) exp_wr = 1;
        else m_over = 1;
      end else if (m_idx == 1) begin
        m_mod = (data == 8'd1);
      end else if (m_idx == 254) begin
        if (addr == 0) m_dip1 = data;
        else if (addr == 1) m_dip2 = data;
      end
    end
    ioctl_wr = wr; ioctl_addr = 25'(addr); ioctl_dout = data;
    tick();
    ioctl_wr = 1'b0;
    if (dn_wr === 1'b1) pulses++;
    check("dn_wr", dn_wr, exp_wr);
    if (exp_wr) begin
      check("dn_addr", dn_addr, 17'(addr));
      check("dn_data", dn_data, data);
    end
    check("mod", mod_shotrider, m_mod);
    check("dip1", dip_switch_1, m_dip1);
    check("dip2", dip_switch_2, m_dip2);
    check("busy", dl_busy, in_hold || (m_active && is_real(m_idx)));
    check("core_reset", core_reset, in_hold || (m_active && is_real(m_idx)));
  endtask

  task automatic dl_start(input int idx, input bit wr, input int addr, input logic [7:0] data);
    ioctl_download = 1'b1; ioctl_index = 8'(idx);
    m_idx = idx; m_active = 1;
    if (is_real(idx)) in_hold = 0;
    if (idx == 0) begin m_cnt = 0; m_over = 0; end
    drive_byte(wr, addr, data);
  endtask

  task automatic dl_end();
    ioctl_download = 1'b0; m_active = 0;
    if (is_real(m_idx)) begin
      in_hold = 1;
      if (m_idx == 0) m_err = (m_cnt != int'(RS)) || m_over;
    end
    tick();
    check("end_err", rom_size_err, m_err);
    check("end_busy", dl_busy, in_hold);
  endtask

  task automatic wait_idle(input int exp_n);
    int n = 0;
    while (dl_busy === 1'b1 && n < 20 * int'(HC)) begin tick(); n++; end
    check("hold_len", n, exp_n);
    check("idle_core_reset", core_reset, 1'b0);
    in_hold = 0;
  endtask

  task automatic idle_ticks(input int k);
    for (int i = 0; i < k; i++) drive_byte(0, 0, 8'h00);
  endtask

  function automatic rec_t mk(input bit s, input logic [7:0] i, input logic [24:0] a,
                              input logic [7:0] d, input bit w, input bit m,
                              input logic [7:0] e1, input logic [7:0] e2, input bit b);
    rec_t r;
    r.start = s; r.idx = i; r.addr = a; r.data = d; r.exp_wr = w;
    r.exp_mod = m; r.exp_d1 = e1; r.exp_d2 = e2; r.exp_busy = b;
    return r;
  endfunction

  int   sel, idx, nb, extra, a, k0;
  bit   coin, cur_real, active;
  rec_t r;

  initial begin
    reset = 1'b1; user_reset = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0; ioctl_index = '0;
    m_dip1 = D1; m_dip2 = D2; m_mod = 0; m_err = 0; m_over = 0;
    m_active = 0; in_hold = 0; m_idx = 3; m_cnt = 0;

    // Reset values and post-reset hold length.
    tick(); tick();
    check("rst_dn_addr", dn_addr, 17'd0);
    check("rst_dn_data", dn_data, 8'd0);
    check("rst_dn_wr", dn_wr, 1'b0);
    check("rst_mod", mod_shotrider, 1'b0);
    check("rst_dip1", dip_switch_1, D1);
    check("rst_dip2", dip_switch_2, D2);
    check("rst_core_reset", core_reset, 1'b1);
    check("rst_err", rom_size_err, 1'b0);
    check("rst_busy", dl_busy, 1'b1);
    reset = 1'b0;
    wait_idle(HC + 1);
    check("post_rst_dip1", dip_switch_1, D1);

    // Hand-computed vectors; a start row's byte coincides with download entry.
    tbl[0]  = mk(1, 8'd1,   25'd0,  8'h00, 0, 0, D1,    D2,    1);
    tbl[1]  = mk(0, 8'd1,   25'd1,  8'h01, 0, 1, D1,    D2,    1);
    tbl[2]  = mk(1, 8'd254, 25'd0,  8'h5A, 0, 1, 8'h5A, D2,    1);
    tbl[3]  = mk(0, 8'd254, 25'd1,  8'hA5, 0, 1, 8'h5A, 8'hA5, 1);
    tbl[4]  = mk(0, 8'd254, 25'd8,  8'h00, 0, 1, 8'h5A, 8'hA5, 1);
    tbl[5]  = mk(0, 8'd254, 25'd2,  8'h77, 0, 1, 8'h5A, 8'hA5, 1);
    tbl[6]  = mk(1, 8'd3,   25'd0,  8'h11, 0, 1, 8'h5A, 8'hA5, 0);
    tbl[7]  = mk(0, 8'd3,   25'd1,  8'h22, 0, 1, 8'h5A, 8'hA5, 0);
    tbl[8]  = mk(1, 8'd1,   25'd0,  8'h00, 0, 0, 8'h5A, 8'hA5, 1);
    tbl[9]  = mk(1, 8'd0,   25'd5,  8'h9E, 1, 0, 8'h5A, 8'hA5, 1);
    tbl[10] = mk(0, 8'd0,   25'(RS), 8'h44, 0, 0, 8'h5A, 8'hA5, 1);
    active = 0; cur_real = 0;
    for (int i = 0; i < 11; i++) begin
      r = tbl[i];
      if (r.start) begin
        if (active) begin
          ioctl_download = 1'b0; tick();
          if (cur_real) wait_idle(HC + 1);
        end
        ioctl_download = 1'b1; ioctl_index = r.idx; active = 1;
        cur_real = is_real(int'(r.idx));
      end
      ioctl_wr = 1'b1; ioctl_addr = r.addr; ioctl_dout = r.data;
      tick();
      ioctl_wr = 1'b0;
      check("tbl_dn_wr", dn_wr, r.exp_wr);
      if (r.exp_wr) begin
        check("tbl_dn_addr", dn_addr, r.addr[16:0]);
        check("tbl_dn_data", dn_data, r.data);
      end
      check("tbl_mod", mod_shotrider, r.exp_mod);
      check("tbl_dip1", dip_switch_1, r.exp_d1);
      check("tbl_dip2", dip_switch_2, r.exp_d2);
      check("tbl_busy", dl_busy, r.exp_busy);
    end
    ioctl_download = 1'b0; tick();
    check("tbl_rom_err", rom_size_err, 1'b1);
    wait_idle(HC + 1);

    // Async reset with a ROM write in flight.
    ioctl_download = 1'b1; ioctl_index = 8'd0; tick();
    ioctl_wr = 1'b1; ioctl_addr = 25'd3; ioctl_dout = 8'h3C; tick();
    ioctl_wr = 1'b0;
    check("inflight_dn_wr", dn_wr, 1'b1);
    reset = 1'b1; #1;
    check("arst_dn_wr", dn_wr, 1'b0);
    check("arst_dip1", dip_switch_1, D1);
    check("arst_dip2", dip_switch_2, D2);
    check("arst_busy", dl_busy, 1'b1);
    check("arst_err", rom_size_err, 1'b0);
    ioctl_download = 1'b0; tick();
    reset = 1'b0;
    wait_idle(HC + 1);
    m_dip1 = D1; m_dip2 = D2; m_mod = 0; m_err = 0;

    // user_reset in IDLE reaches core_reset one cycle later.
    user_reset = 1'b1; tick();
    check("ureset_core_reset", core_reset, 1'b1);
    check("ureset_busy", dl_busy, 1'b0);
    user_reset = 1'b0; tick();
    check("ureset_release", core_reset, 1'b0);

    // Exact-length ROM download with random gaps.
    pulses = 0;
    dl_start(0, 1, 0, 8'($urandom));
    for (int k = 1; k < int'(RS); k++) begin
      if ($urandom_range(0, 3) == 0) drive_byte(0, 0, 8'h00);
      drive_byte(1, k, 8'($urandom));
    end
    dl_end();
    check("rom_pulses", pulses, RS);
    check("rom_ok_err", rom_size_err, 1'b0);
    wait_idle(HC + 1);

    // Short by one, plus two over-range bytes.
    pulses = 0;
    dl_start(0, 1, 0, 8'h10);
    for (int k = 1; k < int'(RS) - 1; k++) drive_byte(1, k, 8'(k));
    drive_byte(1, int'(RS), 8'hEE);
    drive_byte(1, int'(RS) + 1, 8'hEF);
    dl_end();
    check("over_pulses", pulses, RS - 17'd1);
    check("over_err", rom_size_err, 1'b1);
    wait_idle(HC + 1);
    // Right byte count but one over-range address.
    dl_start(0, 1, 0, 8'h20);
    for (int k = 1; k < int'(RS) - 1; k++) drive_byte(1, k, 8'(k));
    drive_byte(1, int'(RS), 8'hEE);
    dl_end();
    check("cnt_eq_over_err", rom_size_err, 1'b1);
    wait_idle(HC + 1);
    dl_start(0, 1, 0, 8'h30);
    for (int k = 1; k < int'(RS); k++) drive_byte(1, k, 8'(k));
    dl_end();
    check("err_cleared", rom_size_err, 1'b0);

    // New download during HOLD: no IDLE visit, first write accepted.
    idle_ticks(3);
    dl_start(254, 1, 1, 8'h66);
    check("rehold_dip2", dip_switch_2, 8'h66);
    drive_byte(1, 0, 8'h99);
    dl_end();
    wait_idle(HC + 1);

    // Index change mid-download is ignored.
    dl_start(1, 0, 0, 8'h00);
    ioctl_index = 8'd0;
    drive_byte(1, 2, 8'h01);
    check("latched_idx_mod", mod_shotrider, 1'b1);
    drive_byte(1, 3, 8'h00);
    dl_end();
    wait_idle(HC + 1);

    // Randomized downloads against the model.
    for (int it = 0; it < 24; it++) begin
      sel = $urandom_range(0, 3);
      idx = (sel == 0) ? 0 : (sel == 1) ? 1 : (sel == 2) ? 254 : 3;
      if (in_hold) begin
        extra = $urandom_range(0, HC - 1);
        idle_ticks(extra);
        if (idx == 3 || $urandom_range(0, 1) == 0) wait_idle(HC + 1 - extra);
      end
      nb = (idx == 0) ? $urandom_range(int'(RS) - 2, int'(RS) + 1) : $urandom_range(1, 5);
      coin = 1'($urandom_range(0, 1));
      dl_start(idx, coin, 0, (idx == 1) ? 8'($urandom_range(0, 2)) : 8'($urandom));
      if (is_real(idx)) ioctl_index = 8'($urandom);
      k0 = coin ? 1 : 0;
      for (int k = k0; k < nb; k++) begin
        if ($urandom_range(0, 5) == 0) drive_byte(0, 0, 8'h00);
        if (idx == 0) a = ($urandom_range(0, 7) == 0) ? $urandom_range(0, int'(RS) + 7) : k;
        else if (idx == 254) a = $urandom_range(0, 11);
        else a = $urandom_range(0, 3);
        drive_byte(1, a, (idx == 1) ? 8'($urandom_range(0, 2)) : 8'($urandom));
      end
      dl_end();
    end
    if (in_hold) wait_idle(HC + 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
